// File: rtl/seven_seg_scanner.sv
//==============================================================================
// Module      : seven_seg_scanner
// Description : Time-multiplexed driver for a 4-digit seven-segment display.
//               Digit values, enables and decimal points are captured once per
//               frame into shadow registers, so a frame never shows a mix of
//               old and new values. Each digit slot opens with a blanking
//               window to suppress ghosting. Anode, cathode and decimal-point
//               outputs are active-low and registered.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module seven_seg_scanner #(
  parameter int DIV   = 1000,  // clock cycles per digit slot (>= 2)
  parameter int BLANK = 50     // leading cycles of each slot with anodes off
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] digit0_i,
  input  logic [3:0] digit1_i,
  input  logic [3:0] digit2_i,
  input  logic [3:0] digit3_i,
  input  logic       digit0_en_i,
  input  logic       digit1_en_i,
  input  logic       digit2_en_i,
  input  logic       digit3_en_i,
  input  logic [3:0] dp_i,
  output logic [3:0] anode_o,
  output logic [6:0] segments_o,
  output logic       dp_o
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0]       div_cnt;
  logic [1:0]          idx;
  logic [3:0][3:0]     shadow_digit;
  logic [3:0]          shadow_en;
  logic [3:0]          shadow_dp;

  logic                slot_wrap;
  logic                frame_end;
  logic                in_blank;
  logic                active;
  logic [3:0]          cur_digit;
  logic [6:0]          cur_seg;

  assign slot_wrap = (div_cnt == CNT_LAST);
  assign frame_end = slot_wrap && (idx == 2'd3);

  // Blanking window at the start of every slot; absent entirely when BLANK is 0
  // so the digit stays lit for the whole slot.
  if (BLANK == 0) begin : g_no_blank
    assign in_blank = 1'b0;
  end else begin : g_blank
    assign in_blank = (div_cnt < CW'(BLANK));
  end

  assign cur_digit = shadow_digit[idx];
  assign active    = !in_blank && shadow_en[idx];

  // Prescaler and digit index: one slot per DIV cycles, four slots per frame.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_cnt <= '0;
      idx     <= 2'd0;
    end else if (slot_wrap) begin
      div_cnt <= '0;
      idx     <= idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  // Shadow capture on the last cycle of a frame only, so a frame never tears.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_digit <= '0;
      shadow_en    <= '0;
      shadow_dp    <= '0;
    end else if (frame_end) begin
      shadow_digit <= {digit3_i, digit2_i, digit1_i, digit0_i};
      shadow_en    <= {digit3_en_i, digit2_en_i, digit1_en_i, digit0_en_i};
      shadow_dp    <= dp_i;
    end
  end

  // Full hex decode to active-low {g,f,e,d,c,b,a}.
  always_comb begin
    cur_seg = 7'h7F;
    case (cur_digit)
      4'h0: cur_seg = 7'h40;
      4'h1: cur_seg = 7'h79;
      4'h2: cur_seg = 7'h24;
      4'h3: cur_seg = 7'h30;
      4'h4: cur_seg = 7'h19;
      4'h5: cur_seg = 7'h12;
      4'h6: cur_seg = 7'h02;
      4'h7: cur_seg = 7'h78;
      4'h8: cur_seg = 7'h00;
      4'h9: cur_seg = 7'h10;
      4'hA: cur_seg = 7'h08;
      4'hB: cur_seg = 7'h03;
      4'hC: cur_seg = 7'h46;
      4'hD: cur_seg = 7'h21;
      4'hE: cur_seg = 7'h06;
      4'hF: cur_seg = 7'h0E;
      default: cur_seg = 7'h7F;
    endcase
  end

  // Registered pin drivers; dark whenever the slot is blanked or disabled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      anode_o    <= 4'hF;
      segments_o <= 7'h7F;
      dp_o       <= 1'b1;
    end else if (active) begin
      anode_o    <= ~(4'b0001 << idx);
      segments_o <= cur_seg;
      dp_o       <= ~shadow_dp[idx];
    end else begin
      anode_o    <= 4'hF;
      segments_o <= 7'h7F;
      dp_o       <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
//==============================================================================
// Module      : tb_seven_seg_scanner
// Description : Directed bench for seven_seg_scanner with DIV=4, BLANK=1.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_seven_seg_scanner;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [3:0] digit0_i, digit1_i, digit2_i, digit3_i;
  logic       digit0_en_i, digit1_en_i, digit2_en_i, digit3_en_i;
  logic [3:0] dp_i;
  logic [3:0] anode_o;
  logic [6:0] segments_o;
  logic       dp_o;

  int checks = 0;
  int errors = 0;
  logic [6:0] seg_tab [16];

  seven_seg_scanner #(.DIV(4), .BLANK(1)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .digit0_i    (digit0_i),
    .digit1_i    (digit1_i),
    .digit2_i    (digit2_i),
    .digit3_i    (digit3_i),
    .digit0_en_i (digit0_en_i),
    .digit1_en_i (digit1_en_i),
    .digit2_en_i (digit2_en_i),
    .digit3_en_i (digit3_en_i),
    .dp_i        (dp_i),
    .anode_o     (anode_o),
    .segments_o  (segments_o),
    .dp_o        (dp_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock and sample just after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] an,
                     input logic [6:0] seg, input logic dp);
    checks++;
    assert ({anode_o, segments_o, dp_o} === {an, seg, dp})
    else begin
      errors++;
      $error("FAIL %s: observed anode=%h seg=%h dp=%b expected anode=%h seg=%h dp=%b",
             tag, anode_o, segments_o, dp_o, an, seg, dp);
    end
  endtask

  // One 4-cycle slot: blank cycle, then three lit (or dark) cycles.
  task automatic slot(input string tag, input logic [3:0] an,
                      input logic [6:0] seg, input logic dp);
    step();
    chk({tag, "_blank"}, 4'hF, 7'h7F, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk(tag, an, seg, dp);
    end
  endtask

  initial begin
    seg_tab[0]  = 7'h40; seg_tab[1]  = 7'h79; seg_tab[2]  = 7'h24; seg_tab[3]  = 7'h30;
    seg_tab[4]  = 7'h19; seg_tab[5]  = 7'h12; seg_tab[6]  = 7'h02; seg_tab[7]  = 7'h78;
    seg_tab[8]  = 7'h00; seg_tab[9]  = 7'h10; seg_tab[10] = 7'h08; seg_tab[11] = 7'h03;
    seg_tab[12] = 7'h46; seg_tab[13] = 7'h21; seg_tab[14] = 7'h06; seg_tab[15] = 7'h0E;

    // Reset held with arbitrary inputs: outputs dark.
    rst_i = 1'b1;
    digit0_i = 4'h5; digit1_i = 4'h6; digit2_i = 4'h7; digit3_i = 4'h9;
    {digit3_en_i, digit2_en_i, digit1_en_i, digit0_en_i} = 4'hF;
    dp_i = 4'hF;
    #2;
    chk("reset_async", 4'hF, 7'h7F, 1'b1);
    step(); step();
    chk("reset_held", 4'hF, 7'h7F, 1'b1);

    // Scan-order values; release reset on a falling edge.
    digit0_i = 4'h8; digit1_i = 4'h3; digit2_i = 4'h2; digit3_i = 4'h1;
    dp_i = 4'h0;
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("first_frame_dark", 4'hF, 7'h7F, 1'b1);
    end

    // Second frame: digit0..digit3 in order.
    slot("scan_d0", 4'hE, 7'h00, 1'b1);
    slot("scan_d1", 4'hD, 7'h30, 1'b1);
    slot("scan_d2", 4'hB, 7'h24, 1'b1);
    slot("scan_d3", 4'h7, 7'h79, 1'b1);

    // Tear-free: change inputs during the digit2 slot.
    slot("tear_d0", 4'hE, 7'h00, 1'b1);
    slot("tear_d1", 4'hD, 7'h30, 1'b1);
    step();
    digit0_i = 4'hF;
    digit3_i = 4'h4;
    chk("tear_d2_blank", 4'hF, 7'h7F, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("tear_d2", 4'hB, 7'h24, 1'b1);
    end
    slot("tear_d3_old", 4'h7, 7'h79, 1'b1);

    // Next frame picks up the new values; change enables/dp mid-frame.
    slot("new_d0", 4'hE, 7'h0E, 1'b1);
    digit1_en_i = 1'b0;
    digit3_en_i = 1'b0;
    dp_i = 4'b0001;
    slot("new_d1", 4'hD, 7'h30, 1'b1);
    slot("new_d2", 4'hB, 7'h24, 1'b1);
    slot("new_d3", 4'h7, 7'h19, 1'b1);

    // Enables and decimal point take effect; frame still 16 cycles.
    slot("en_d0", 4'hE, 7'h0E, 1'b0);
    slot("en_d1_off", 4'hF, 7'h7F, 1'b1);
    slot("en_d2", 4'hB, 7'h24, 1'b1);
    slot("en_d3_off", 4'hF, 7'h7F, 1'b1);
    slot("en2_d0", 4'hE, 7'h0E, 1'b0);

    // Async reset while anode B is showing.
    slot("pre_rst_d1_off", 4'hF, 7'h7F, 1'b1);
    step();
    step();
    chk("pre_rst_d2", 4'hB, 7'h24, 1'b1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("mid_slot_reset", 4'hF, 7'h7F, 1'b1);
    step();

    // Restart: blank frame, then decode sweep on digit0.
    {digit3_en_i, digit2_en_i, digit1_en_i, digit0_en_i} = 4'hF;
    dp_i = 4'h0;
    digit0_i = 4'h0;
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("restart_dark", 4'hF, 7'h7F, 1'b1);
    end
    for (int v = 0; v < 16; v++) begin
      digit0_i = 4'(v + 1);
      step();
      step();
      chk($sformatf("decode_%0h", v), 4'hE, seg_tab[v], 1'b1);
      for (int i = 0; i < 14; i++) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
